// File: rtl/move_replayer_if.sv
// Move-request channel between the replayer and the cube move engine.
// The replayer drives a move (face, quarter-turn count) with valid; the
// engine accepts it with ready. A move transfers when valid & ready.
interface move_replayer_if;
    logic       mv_valid;
    logic [2:0] mv_face;
    logic [2:0] mv_rot;
    logic       mv_ready;

    modport master (
        output mv_valid,
        output mv_face,
        output mv_rot,
        input  mv_ready
    );

    modport slave (
        input  mv_valid,
        input  mv_face,
        input  mv_rot,
        output mv_ready
    );
endinterface

// File: rtl/move_replayer.sv
// LIFO log of applied cube moves with reverse replay. Moves recorded while
// idle are merged with the top entry when they turn the same face, otherwise
// pushed. On solve_start the log is popped one entry at a time and the
// inverse move is offered to the move engine, with an optional idle gap
// between consecutive moves.
module move_replayer #(
    parameter int DEPTH      = 64,
    parameter int PTR_W      = 6,
    parameter int GAP_CYCLES = 25000000,
    parameter int GAP_W      = 25
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rec_valid,
    input  logic [2:0]           rec_face,
    input  logic [2:0]           rec_rot,
    input  logic                 clear,
    input  logic                 solve_start,
    input  logic                 abort,
    move_replayer_if.master      mv,
    output logic                 busy,
    output logic                 done,
    output logic [PTR_W:0]       depth,
    output logic                 overflow
);

    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, GAP, FINISH} state_t;

    // One log entry; the quarter-turn count of a stored entry is always 1..3.
    typedef struct packed {
        logic [2:0] face;
        logic [1:0] rot;
    } entry_t;

    localparam logic [PTR_W:0]   ONE      = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   FULL     = (PTR_W+1)'(DEPTH);
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES == 0) ? '0 : GAP_W'(GAP_CYCLES - 1);

    state_t           state, state_nxt;
    entry_t           log_mem [DEPTH];
    entry_t           top, entry_q, wr_data;
    logic [PTR_W:0]   depth_q, depth_nxt, depth_m1;
    logic [PTR_W-1:0] wr_addr;
    logic             wr_en;
    logic             ovf_q, ovf_nxt;
    logic             done_q;
    logic             rec_ok, hs;
    logic [1:0]       rot_sum, inv_rot;
    logic [GAP_W-1:0] gap_q;

    assign depth_m1 = depth_q - ONE;
    assign top      = log_mem[depth_m1[PTR_W-1:0]];
    assign rec_ok   = rec_valid && (rec_rot != 3'd0) && !rec_rot[2] && (rec_face < 3'd6);
    assign rot_sum  = top.rot + rec_rot[1:0];
    assign hs       = (state == ISSUE) && mv.mv_ready;
    assign inv_rot  = 2'd0 - entry_q.rot;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Log bookkeeping: clear / merge / push while idle, pop on each accepted move.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
        depth_nxt = depth_q;
        ovf_nxt   = ovf_q;
        wr_en     = 1'b0;
        wr_addr   = depth_m1[PTR_W-1:0];
        wr_data   = top;
        if (state == IDLE) begin
            if (clear) begin
                depth_nxt = '0;
                ovf_nxt   = 1'b0;
            end else if (rec_ok) begin
                if ((depth_q != '0) && (top.face == rec_face)) begin
                    if (rot_sum == 2'd0) begin
                        depth_nxt = depth_m1;
                    end else begin
                        wr_en       = 1'b1;
                        wr_data.rot = rot_sum;
                    end
                end else if (depth_q == FULL) begin
                    ovf_nxt = 1'b1;
                end else begin
                    wr_en        = 1'b1;
                    wr_addr      = depth_q[PTR_W-1:0];
                    wr_data.face = rec_face;
                    wr_data.rot  = rec_rot[1:0];
                    depth_nxt    = depth_q + ONE;
                end
            end
        end else if (hs) begin
            depth_nxt = depth_m1;
        end
    end

    // Log RAM write port.
    // NOTE: the log RAM has no reset; entries at or above depth are never read, so stale contents are harmless.
    always_ff @(posedge clk) begin
        if (wr_en) log_mem[wr_addr] <= wr_data;
    end

    // Datapath registers: depth, overflow, fetched entry, gap counter, empty-solve done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            depth_q <= '0;
            ovf_q   <= 1'b0;
            entry_q <= '0;
            gap_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            depth_q <= depth_nxt;
            ovf_q   <= ovf_nxt;
            done_q  <= (state == IDLE) && solve_start && (depth_nxt == '0);
            if (state == FETCH) entry_q <= top;
            if (hs)                                 gap_q <= GAP_LOAD;
            else if ((state == GAP) && (gap_q != '0)) gap_q <= gap_q - GAP_W'(1);
        end
    end

    // Next-state logic; abort overrides everything outside IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (solve_start && (depth_nxt != '0)) state_nxt = FETCH;
            FETCH:  state_nxt = ISSUE;
            ISSUE: begin
                if (hs) begin
                    if (GAP_CYCLES == 0) state_nxt = (depth_nxt != '0) ? FETCH : FINISH;
                    else                 state_nxt = GAP;
                end
            end
            GAP:    if (gap_q == '0) state_nxt = (depth_q != '0) ? FETCH : FINISH;
            FINISH: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if ((state != IDLE) && abort) state_nxt = IDLE;
    end

    // Outputs: the move request is the inverse of the fetched entry.
    always_comb begin
        mv.mv_valid = (state == ISSUE);
        mv.mv_face  = entry_q.face;
        mv.mv_rot   = {1'b0, inv_rot};
        busy        = (state != IDLE);
        done        = (state == FINISH) || done_q;
        depth       = depth_q;
        overflow    = ovf_q;
    end

endmodule
